// File: rtl/sc_rr_arbiter.sv
// rtl/sc_rr_arbiter.sv - round-robin arbiter sharing one gate datapath (optional macro SC_ARB_TXN_COUNT_EN)

module sc_rr_gate (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e
);
    assign d = (a & b) | ~c;
    assign e = ~c;
endmodule

module sc_rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op_a,
    input  logic [N_REQ-1:0] op_b,
    input  logic [N_REQ-1:0] op_c,
    output logic [N_REQ-1:0] gnt,
    output logic             busy,
    output logic             rsp_valid,
    output logic [ID_W-1:0]  rsp_id,
    output logic             rsp_d,
    output logic             rsp_e
`ifdef SC_ARB_TXN_COUNT_EN
    ,
    output logic [15:0]      txn_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  win_q, win_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             c_q, c_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             busy_q, busy_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_d_q, rsp_d_d;
    logic             rsp_e_q, rsp_e_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_rot_full;
    logic [N_REQ-1:0]   req_rot;
    logic [ID_W:0]      win_sum;
    logic [ID_W-1:0]    win_c;
    logic               gate_d;
    logic               gate_e;

    // The single shared gate, fed only from the latched operands of the winner
    sc_rr_gate u_gate (
        .a (a_q),
        .b (b_q),
        .c (c_q),
        .d (gate_d),
        .e (gate_e)
    );

    // Rotate requests so the pointer sits at bit 0, pick the lowest set bit, map back
    always_comb begin
        req_dbl      = {req, req};
        req_rot_full = req_dbl >> ptr_q;
        req_rot      = req_rot_full[N_REQ-1:0];
        win_sum      = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                win_sum = {1'b0, ptr_q} + (ID_W+1)'(j);
            end
        end
        if (win_sum >= (ID_W+1)'(N_REQ)) begin
            win_sum = win_sum - (ID_W+1)'(N_REQ);
        end
        win_c = win_sum[ID_W-1:0];
    end

    // Next-state and registered-output logic; every register holds unless updated
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        win_d       = win_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        gnt_d       = gnt_q;
        busy_d      = busy_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_d_d     = rsp_d_q;
        rsp_e_d     = rsp_e_q;
        case (state_q)
            S_IDLE: begin
                gnt_d       = '0;
                busy_d      = 1'b0;
                rsp_valid_d = 1'b0;
                if (|req) begin
                    win_d   = win_c;
                    a_d     = op_a[win_c];
                    b_d     = op_b[win_c];
                    c_d     = op_c[win_c];
                    gnt_d   = N_REQ'(1) << win_c;
                    busy_d  = 1'b1;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                rsp_d_d     = gate_d;
                rsp_e_d     = gate_e;
                rsp_id_d    = win_q;
                rsp_valid_d = 1'b1;
                gnt_d       = '0;
                busy_d      = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                ptr_d       = (win_q == ID_W'(N_REQ - 1)) ? '0 : win_q + 1'b1;
                rsp_valid_d = 1'b0;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                gnt_d       = '0;
                busy_d      = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            c_q         <= 1'b0;
            gnt_q       <= '0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_d_q     <= 1'b0;
            rsp_e_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            gnt_q       <= gnt_d;
            busy_q      <= busy_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_d_q     <= rsp_d_d;
            rsp_e_q     <= rsp_e_d;
        end
    end

    assign gnt       = gnt_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_d     = rsp_d_q;
    assign rsp_e     = rsp_e_q;

`ifdef SC_ARB_TXN_COUNT_EN
    logic [15:0] txn_count_q, txn_count_d;

    // Count every cycle a response is presented; wraps naturally at 16 bits
    always_comb begin
        txn_count_d = txn_count_q;
        if (rsp_valid_q) begin
            txn_count_d = txn_count_q + 16'd1;
        end
    end

    // Transaction counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            txn_count_q <= '0;
        end else begin
            txn_count_q <= txn_count_d;
        end
    end

    assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_sc_rr_arbiter.sv
// tb/tb_sc_rr_arbiter.sv - directed table-driven bench for sc_rr_arbiter

module tb_sc_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic [3:0] op_a = '0;
    logic [3:0] op_b = '0;
    logic [3:0] op_c = '0;
    logic [3:0] gnt;
    logic       busy;
    logic       rsp_valid;
    logic [1:0] rsp_id;
    logic       rsp_d;
    logic       rsp_e;
`ifdef SC_ARB_TXN_COUNT_EN
    logic [15:0] txn_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    sc_rr_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_c      (op_c),
        .gnt       (gnt),
        .busy      (busy),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_d     (rsp_d),
        .rsp_e     (rsp_e)
`ifdef SC_ARB_TXN_COUNT_EN
        ,
        .txn_count (txn_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] c;
        logic [3:0] gnt;
        logic [1:0] id;
        logic       d;
        logic       e;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One complete transaction from IDLE; operands are scrambled after the sample edge
    task automatic do_txn(input string tag, input logic [3:0] r, input logic [3:0] a,
                          input logic [3:0] b, input logic [3:0] c, input logic [3:0] eg,
                          input logic [1:0] eid, input logic ed, input logic ee);
        req = r; op_a = a; op_b = b; op_c = c;
        tick();
        chk({tag, ".gnt"}, 32'(gnt), 32'(eg));
        chk({tag, ".busy_g"}, 32'(busy), 32'd1);
        chk({tag, ".valid_g"}, 32'(rsp_valid), 32'd0);
        req = '0; op_a = ~a; op_b = ~b; op_c = ~c;
        tick();
        chk({tag, ".valid_r"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".gnt_r"}, 32'(gnt), 32'd0);
        chk({tag, ".id"}, 32'(rsp_id), 32'(eid));
        chk({tag, ".d"}, 32'(rsp_d), 32'(ed));
        chk({tag, ".e"}, 32'(rsp_e), 32'(ee));
        tick();
        chk({tag, ".valid_i"}, 32'(rsp_valid), 32'd0);
        chk({tag, ".busy_i"}, 32'(busy), 32'd0);
        chk({tag, ".hold"}, {29'd0, rsp_id, rsp_d}, {29'd0, eid, ed});
    endtask

    initial begin
        // Each winner's own operand bits are set as listed; other bits are inverted to expose mis-indexing
        vecs[0] = '{4'b0001, 4'b0001, 4'b1110, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b1};
        vecs[1] = '{4'b0100, 4'b1011, 4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0};
        vecs[2] = '{4'b1000, 4'b1000, 4'b1000, 4'b0111, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[3] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b0};
        vecs[4] = '{4'b1011, 4'b0111, 4'b0111, 4'b1000, 4'b1000, 2'd3, 1'b0, 1'b0};
        vecs[5] = '{4'b0110, 4'b0010, 4'b1101, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0};
        vecs[6] = '{4'b0011, 4'b1110, 4'b1110, 4'b1110, 4'b0001, 2'd0, 1'b1, 1'b1};

        rst = 1'b1;
        tick();
        tick();
        chk("rst.gnt", 32'(gnt), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.valid", 32'(rsp_valid), 32'd0);
        chk("rst.rsp", {29'd0, rsp_id, rsp_d}, 32'd0);
        chk("rst.e", 32'(rsp_e), 32'd0);
        rst = 1'b0;
        tick();
        chk("idle.gnt", 32'(gnt), 32'd0);

        for (int i = 0; i < 7; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].c,
                   vecs[i].gnt, vecs[i].id, vecs[i].d, vecs[i].e);
        end

        // Fairness from a freshly reset pointer: all four hold req, winner drops and re-raises
        rst = 1'b1;
        tick();
        rst = 1'b0;
        op_a = '0; op_b = '0; op_c = '0;
        for (int t = 0; t < 5; t++) begin
            int w;
            w = t % 4;
            req = 4'b1111;
            tick();
            chk($sformatf("fair%0d.gnt", t), 32'(gnt), 32'd1 << w);
            req[w] = 1'b0;
            tick();
            chk($sformatf("fair%0d.valid", t), 32'(rsp_valid), 32'd1);
            chk($sformatf("fair%0d.id", t), 32'(rsp_id), 32'(w));
            req = 4'b1111;
            tick();
            chk($sformatf("fair%0d.gap", t), 32'(rsp_valid), 32'd0);
        end
        req = '0;
        tick();

        // Pointer wrap: pointer is 1 here
        do_txn("wrap_a", 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1);
        do_txn("wrap_b", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
        do_txn("wrap_c", 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1);

        // Move pointer away from 0, then reset during GRANT
        do_txn("pre_rst", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
        req = 4'b0100; op_a = 4'b0000; op_b = 4'b0000; op_c = 4'b0100;
        tick();
        chk("mid.gnt", 32'(gnt), 32'b0100);
        rst = 1'b1;
        req = '0;
        tick();
        chk("mid.gnt0", 32'(gnt), 32'd0);
        chk("mid.valid0", 32'(rsp_valid), 32'd0);
        chk("mid.busy0", 32'(busy), 32'd0);
        chk("mid.rsp0", {29'd0, rsp_id, rsp_d}, 32'd0);
        rst = 1'b0;
        tick();
        chk("mid.valid1", 32'(rsp_valid), 32'd0);
        tick();
        chk("mid.valid2", 32'(rsp_valid), 32'd0);
        req = 4'b1111;
        tick();
        chk("mid.ptr0", 32'(gnt), 32'b0001);
        req = '0;
        tick();
        tick();

`ifdef SC_ARB_TXN_COUNT_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("cnt.rst", 32'(txn_count), 32'd0);
        for (int k = 0; k < 5; k++) begin
            do_txn($sformatf("cnt%0d", k), 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
        end
        chk("cnt.five", 32'(txn_count), 32'd5);
        dut.txn_count_q = 16'hFFFF;
        do_txn("cnt_wrap", 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
        chk("cnt.wrap", 32'(txn_count), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
